// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: 3-word register window, TX FIFO, 8N1 serialiser.
// Define UART_PARITY_EN for 8E1 framing (extra even-parity bit, STATUS[8]=1).
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] adr,
   input  logic [31:0] wd,
   output logic        sel,
   output logic [31:0] rd,
   output logic        tx,
   output logic        busy
);
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
`ifdef UART_PARITY_EN
   localparam logic PAR_CAP = 1'b1;
`else
   localparam logic PAR_CAP = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [2:0]          bit_q, bit_d;
   logic [7:0]          shift_q, shift_d;
`ifdef UART_PARITY_EN
   logic                par_q, par_d;
`endif
   logic                tx_q, tx_d;
   logic                busy_q, busy_d;
   logic                ovf_q, ovf_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]          mem_q [FIFO_DEPTH];

   logic [29:0] woff_c;
   logic        wr_tx_c, wr_stat_c;
   logic        full_c, empty_c, pop_c, push_ok_c, baud_end_c;
   logic [7:0]  head_c;
   logic [31:0] status_c;
   logic        unused_c;

   // Word offset from the window base; wraps high for addresses below it
   assign woff_c     = adr[31:2] - BASE_ADDR[31:2];
   assign sel        = (woff_c < 30'd3);
   assign wr_tx_c    = memwrite && sel && (woff_c[1:0] == 2'd0);
   assign wr_stat_c  = memwrite && sel && (woff_c[1:0] == 2'd1);
   assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty_c    = (count_q == '0);
   assign head_c     = mem_q[rd_ptr_q];
   assign baud_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
   assign status_c   = {23'd0, PAR_CAP, 4'(count_q), ovf_q, busy_q, full_c, empty_c};
   assign unused_c   = ^{adr[1:0], wd[31:8]};
   assign tx         = tx_q;
   assign busy       = busy_q;

   always_comb begin
      rd = '0;
      if (sel) begin
         case (woff_c[1:0])
            2'd1:    rd = status_c;
            2'd2:    rd = 32'(CLKS_PER_BIT);
            default: rd = '0;
         endcase
      end
   end

   // Frame sequencer; tx_d is derived from the next state so tx comes straight off a flop
   always_comb begin
      state_d = state_q;
      baud_d  = (state_q == S_IDLE) ? '0 : baud_q + BAUD_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef UART_PARITY_EN
      par_d   = par_q;
`endif
      pop_c   = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (!empty_c) begin
               pop_c   = 1'b1;
               shift_d = head_c;
`ifdef UART_PARITY_EN
               par_d   = ^head_c;
`endif
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end_c) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end_c) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  bit_d   = 3'd0;
`ifdef UART_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (baud_end_c) begin
               baud_d  = '0;
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_end_c) begin
               baud_d = '0;
               if (!empty_c) begin
                  pop_c   = 1'b1;
                  shift_d = head_c;
`ifdef UART_PARITY_EN
                  par_d   = ^head_c;
`endif
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // FIFO bookkeeping; a push into a full FIFO survives only if the same edge pops
   always_comb begin
      push_ok_c = wr_tx_c && (!full_c || pop_c);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      if (push_ok_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok_c, pop_c})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (wr_stat_c)                   ovf_d = 1'b0;
      else if (wr_tx_c && !push_ok_c)  ovf_d = 1'b1;
      busy_d = (state_d != S_IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
`ifdef UART_PARITY_EN
         par_q    <= 1'b0;
`endif
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
`ifdef UART_PARITY_EN
         par_q    <= par_d;
`endif
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok_c) mem_q[wr_ptr_q] <= wd[7:0];
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: write schedules are replayed against a frame-level model of
// FIFO acceptance, pop times and serial waveform. Honours UART_PARITY_EN like the RTL.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE  = 32'h0000_0100;
   localparam int          CPB   = 16;
   localparam int          DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int          NB    = 11;
   localparam logic        PARF  = 1'b1;
`else
   localparam int          NB    = 10;
   localparam logic        PARF  = 1'b0;
`endif
   localparam int          F     = NB * CPB;
   localparam int          MAXE  = 4096;

   logic        clk = 1'b0;
   logic        reset, memwrite, sel, tx, busy;
   logic [31:0] adr, wd, rd;
   int          cyc = 0;
   int          vectors = 0;
   int          errors  = 0;

   int          wr_off[$];
   logic [31:0] wr_adr[$];
   logic [31:0] wr_dat[$];
   int          fr_s[$];
   logic [7:0]  fr_b[$];
   int          occ_a [MAXE];
   bit          ovf_a [MAXE];
   bit          busy_a[MAXE];
   int          drv_idx;

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .adr(adr), .wd(wd),
      .sel(sel), .rd(rd), .tx(tx), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $error("FAIL watchdog observed=timeout expected=finish");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (NB == 11 && b == 9) return ^d;
      return 1'b1;
   endfunction

   function automatic logic exp_tx(input int e);
      for (int i = 0; i < fr_s.size(); i++)
         if (e >= fr_s[i] && e < fr_s[i] + F) return frame_bit(fr_b[i], (e - fr_s[i]) / CPB);
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_status(input int occ, input bit ovf, input bit bsy);
      return {23'd0, PARF, 4'(occ), ovf, bsy, (occ == DEPTH), (occ == 0)};
   endfunction

   // Frame-level model: when each byte leaves the FIFO and which writes are kept
   task automatic run_model(output int horizon);
      int          occ, nxt, wi, done_e;
      bit          idle, ovf, pop, push, clr, acc;
      logic [7:0]  q[$];
      logic [7:0]  dat;
      logic [29:0] w;
      logic [31:0] a, base_v;
      base_v = BASE;
      occ = 0; nxt = 0; wi = 0; done_e = -1; idle = 1'b1; ovf = 1'b0; dat = 8'd0;
      fr_s.delete(); fr_b.delete();
      for (int e = 0; e < MAXE; e++) begin
         pop = 1'b0; push = 1'b0; clr = 1'b0;
         if (idle) begin
            if (occ > 0) begin pop = 1'b1; idle = 1'b0; nxt = e + F; end
         end else if (e == nxt) begin
            if (occ > 0) begin pop = 1'b1; nxt = e + F; end
            else idle = 1'b1;
         end
         if (pop) begin fr_s.push_back(e); fr_b.push_back(q.pop_front()); end
         if (wi < wr_off.size() && wr_off[wi] == e) begin
            a = wr_adr[wi];
            w = a[31:2] - base_v[31:2];
            if (w == 30'd0) push = 1'b1;
            else if (w == 30'd1) clr = 1'b1;
            dat = wr_dat[wi][7:0];
            wi++;
         end
         acc = push && (occ < DEPTH || pop);
         if (acc) q.push_back(dat);
         if (push && !acc) ovf = 1'b1;
         if (clr) ovf = 1'b0;
         occ = occ + int'(acc) - int'(pop);
         occ_a[e] = occ; ovf_a[e] = ovf; busy_a[e] = !idle || occ > 0;
         if (done_e < 0 && wi >= wr_off.size() && idle && occ == 0) done_e = e;
      end
      horizon = (done_e < 0) ? MAXE - 8 : done_e + 8;
   endtask

   task automatic drive_edge(input int e);
      if (drv_idx < wr_off.size() && wr_off[drv_idx] == e) begin
         memwrite = 1'b1; adr = wr_adr[drv_idx]; wd = wr_dat[drv_idx];
         drv_idx++;
      end else begin
         memwrite = 1'b0; adr = BASE + 32'd4; wd = $urandom;
      end
   endtask

   // Replay the queued writes (edge offsets from t0) and check every cycle
   task automatic run_scn(input string name);
      int horizon;
      run_model(horizon);
      drv_idx = 0;
      @(negedge clk);
      drive_edge(0);
      for (int rel = 0; rel <= horizon; rel++) begin
         @(negedge clk);
         chk({name, ".tx"}, 32'(tx), 32'(exp_tx(rel)));
         chk({name, ".busy"}, 32'(busy), 32'(busy_a[rel]));
         memwrite = 1'b0; adr = BASE + 32'd4;
         #1;
         chk({name, ".status"}, rd, exp_status(occ_a[rel], ovf_a[rel], busy_a[rel]));
         drive_edge(rel + 1);
      end
      @(negedge clk);
      memwrite = 1'b1; adr = BASE + 32'd4; wd = $urandom;
      @(negedge clk);
      memwrite = 1'b0;
      #1;
      chk({name, ".ovf_clr"}, rd, {23'd0, PARF, 8'h01});
   endtask

   task automatic clear_scn();
      wr_off.delete(); wr_adr.delete(); wr_dat.delete();
   endtask

   task automatic add_wr(input int off, input logic [31:0] a, input logic [31:0] d);
      wr_off.push_back(off); wr_adr.push_back(a); wr_dat.push_back(d);
   endtask

   task automatic gen_random(input int n);
      int          off, k;
      logic [31:0] a;
      clear_scn();
      off = 0;
      for (int i = 0; i < n; i++) begin
         k = $urandom_range(0, 9);
         case (k)
            0, 1, 2, 3, 4, 5: a = BASE + 32'($urandom_range(0, 3));
            6:                a = BASE + 32'd8;
            7:                a = BASE + 32'd4;
            8:                a = BASE + 32'd12;
            default:          a = BASE - 32'd4;
         endcase
         add_wr(off, a, $urandom);
         off += ($urandom_range(0, 3) == 0) ? $urandom_range(2, 200) : 1;
      end
   endtask

   task automatic rd_at(input logic [31:0] a, input string tag, input logic [31:0] e_rd,
                        input logic e_sel);
      @(negedge clk);
      memwrite = 1'b0; adr = a;
      #1;
      chk({tag, ".rd"}, rd, e_rd);
      chk({tag, ".sel"}, 32'(sel), 32'(e_sel));
   endtask

   initial begin
      reset = 1'b1; memwrite = 1'b0; adr = 32'd0; wd = 32'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst.tx", 32'(tx), 32'd1);
      chk("rst.busy", 32'(busy), 32'd0);
      rd_at(BASE + 32'd4, "rst.status", {23'd0, PARF, 8'h01}, 1'b1);
      rd_at(BASE + 32'd8, "rst.divisor", 32'(CPB), 1'b1);
      rd_at(BASE + 32'd11, "rst.divisor_b3", 32'(CPB), 1'b1);
      rd_at(BASE, "rst.txdata", 32'd0, 1'b1);
      rd_at(BASE + 32'd12, "rst.above", 32'd0, 1'b0);
      rd_at(BASE - 32'd4, "rst.below", 32'd0, 1'b0);

      clear_scn();
      add_wr(0, BASE, 32'hFFFF_FFA5);
      run_scn("a5");

      clear_scn();
      add_wr(0, BASE, 32'hDEAD_BE07);
      run_scn("b07");

      clear_scn();
      for (int i = 0; i < 5; i++) add_wr(i, BASE, $urandom);
      run_scn("burst5");

      clear_scn();
      for (int i = 0; i < 6; i++) add_wr(i, BASE, $urandom);
      add_wr(F - 20, BASE + 32'd4, $urandom);
      run_scn("burst6_ovf");

      clear_scn();
      for (int i = 0; i < 5; i++) add_wr(i, BASE, $urandom);
      add_wr(1 + F, BASE, $urandom);
      add_wr(2 + F, BASE + 32'd8, $urandom);
      add_wr(3 + F, BASE - 32'd4, $urandom);
      run_scn("full_pop");

      for (int r = 0; r < 3; r++) begin
         gen_random(8);
         run_scn($sformatf("rand%0d", r));
      end

      // Reset in the middle of a data bit of 8'h00 while a second byte is queued
      @(negedge clk);
      memwrite = 1'b1; adr = BASE; wd = 32'h0000_0000;
      @(negedge clk);
      wd = 32'h0000_003C;
      @(negedge clk);
      memwrite = 1'b0;
      repeat (4 * CPB + 4) @(negedge clk);
      chk("mid.tx_data0", 32'(tx), 32'd0);
      chk("mid.busy", 32'(busy), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("mid.rst_tx", 32'(tx), 32'd1);
      chk("mid.rst_busy", 32'(busy), 32'd0);
      adr = BASE + 32'd4;
      #1;
      chk("mid.rst_status", rd, {23'd0, PARF, 8'h01});
      reset = 1'b0;
      for (int i = 0; i < 2 * F; i++) begin
         @(negedge clk);
         chk("mid.quiet_tx", 32'(tx), 32'd1);
         chk("mid.quiet_busy", 32'(busy), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
